// File: rtl/sigmag_pkg.sv
// Shared types and default widths for the sign/magnitude scan sequencer.
//   scan_state_t : sequencer FSM states
//   sigmag_res_t : {sig, mag} result word written to the result store
package sigmag_pkg;

    localparam int unsigned CH_NUM      = 11;
    localparam int unsigned SEL_W       = 5;
    localparam int unsigned LEN_W       = 25;
    localparam int unsigned CNTR_LENGTH = 24;

    typedef enum logic [2:0] {
        IDLE,
        SEEK,
        CLR,
        ARM,
        WAIT,
        STORE,
        FIN
    } scan_state_t;

    typedef struct packed {
        logic [CNTR_LENGTH-1:0] sig;
        logic [CNTR_LENGTH-1:0] mag;
    } sigmag_res_t;

endpackage

// File: rtl/sigmag_ch_seek.sv
// Combinational next-enabled-channel search.
// Finds the lowest channel >= from whose mask bit is set.
//   mask    : latched channel-enable mask
//   from    : first channel to consider
//   found_c : an enabled channel exists at or above from
//   next_c  : that channel (equals from when none is found)
module sigmag_ch_seek #(
    parameter int unsigned CH_NUM = 11,
    parameter int unsigned SEL_W  = 5
) (
    input  logic [CH_NUM-1:0] mask,
    input  logic [SEL_W-1:0]  from,
    output logic              found_c,
    output logic [SEL_W-1:0]  next_c
);

    // Priority search from low to high; first hit wins.
    always_comb begin
        found_c = 1'b0;
        next_c  = from;
        for (int unsigned i = 0; i < CH_NUM; i++) begin
            if (!found_c && mask[i] && (SEL_W'(i) >= from)) begin
                found_c = 1'b1;
                next_c  = SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/sigmag_scan_ctrl.sv
// Scan sequencer for the sign/magnitude statistics engine: walks the masked
// ADC channels, runs one engine window per channel and writes {sig, mag}
// into the result store at index = channel.
// Ports: pclk/presetn (async active-low); start/abort pulses; ch_mask/length
// latched on an accepted start; meas_* engine handshake; res_we/res_addr/
// res_data result write (res_data laid out as sigmag_res_t); busy; scan_done.
// Build option SIGMAG_SCAN_CONT_EN: scan repeats until abort, scan_done is a
// one-cycle pulse per completed pass. Otherwise single-shot, scan_done sticky.
// SEEK jumps to the next enabled channel in one cycle via sigmag_ch_seek.
module sigmag_scan_ctrl
    import sigmag_pkg::*;
#(
    parameter int unsigned CH_NUM      = sigmag_pkg::CH_NUM,
    parameter int unsigned SEL_W       = sigmag_pkg::SEL_W,
    parameter int unsigned LEN_W       = sigmag_pkg::LEN_W,
    parameter int unsigned CNTR_LENGTH = sigmag_pkg::CNTR_LENGTH
) (
    input  logic                     pclk,
    input  logic                     presetn,
    input  logic                     start,
    input  logic                     abort,
    input  logic [CH_NUM-1:0]        ch_mask,
    input  logic [LEN_W-1:0]         length,
    output logic [SEL_W-1:0]         meas_sel,
    output logic [LEN_W-1:0]         meas_len,
    output logic                     meas_clr,
    input  logic                     meas_done,
    input  logic [CNTR_LENGTH-1:0]   meas_sig,
    input  logic [CNTR_LENGTH-1:0]   meas_mag,
    output logic                     res_we,
    output logic [SEL_W-1:0]         res_addr,
    output logic [2*CNTR_LENGTH-1:0] res_data,
    output logic                     busy,
    output logic                     scan_done
);

    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CH_NUM - 1);

    scan_state_t             state_q, state_d;
    logic [SEL_W-1:0]        idx_q, idx_d;
    logic [CH_NUM-1:0]       mask_q, mask_d;
    logic [LEN_W-1:0]        len_q, len_d;
    logic [SEL_W-1:0]        sel_d;
    logic [LEN_W-1:0]        mlen_d;
    logic                    clr_d;
    logic                    we_d;
    logic [SEL_W-1:0]        addr_d;
    logic [2*CNTR_LENGTH-1:0] data_d;
    logic                    busy_d;
    logic                    done_d;
    logic                    seek_found_c;
    logic [SEL_W-1:0]        seek_idx_c;

    sigmag_ch_seek #(
        .CH_NUM (CH_NUM),
        .SEL_W  (SEL_W)
    ) u_seek (
        .mask    (mask_q),
        .from    (idx_q),
        .found_c (seek_found_c),
        .next_c  (seek_idx_c)
    );

    // State and registered outputs.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            mask_q    <= '0;
            len_q     <= '0;
            meas_sel  <= '0;
            meas_len  <= '0;
            meas_clr  <= 1'b0;
            res_we    <= 1'b0;
            res_addr  <= '0;
            res_data  <= '0;
            busy      <= 1'b0;
            scan_done <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            mask_q    <= mask_d;
            len_q     <= len_d;
            meas_sel  <= sel_d;
            meas_len  <= mlen_d;
            meas_clr  <= clr_d;
            res_we    <= we_d;
            res_addr  <= addr_d;
            res_data  <= data_d;
            busy      <= busy_d;
            scan_done <= done_d;
        end
    end

    // Next state; outputs are decoded from the next state so they are
    // registered yet line up with the cycle spent in that state.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        mask_d  = mask_q;
        len_d   = len_q;
        sel_d   = meas_sel;
        mlen_d  = meas_len;
        addr_d  = res_addr;
        data_d  = res_data;
        done_d  = scan_done;
        clr_d   = 1'b0;
        we_d    = 1'b0;
        busy_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && (length != '0)) begin
                    mask_d  = ch_mask;
                    len_d   = length;
                    idx_d   = '0;
                    done_d  = 1'b0;
                    state_d = SEEK;
                end
            end
            SEEK: begin
                if (seek_found_c) begin
                    idx_d   = seek_idx_c;
                    state_d = CLR;
                end else begin
                    state_d = FIN;
                end
            end
            CLR:  state_d = ARM;
            // A done level left over from the previous window must drop first.
            ARM: begin
                if (!meas_done) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (meas_done) begin
                    data_d  = {meas_sig, meas_mag};
                    state_d = STORE;
                end
            end
            STORE: begin
                if (idx_q == LAST_CH) begin
                    state_d = FIN;
                end else begin
                    idx_d   = idx_q + SEL_W'(1);
                    state_d = SEEK;
                end
            end
            FIN: begin
`ifdef SIGMAG_SCAN_CONT_EN
                idx_d   = '0;
                state_d = SEEK;
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase

        if (abort) begin
            state_d = IDLE;
            done_d  = 1'b0;
        end

        busy_d = (state_d != IDLE);
        if (state_d == CLR) begin
            clr_d  = 1'b1;
            sel_d  = idx_d;
            mlen_d = len_d;
        end
        if (state_d == STORE) begin
            we_d   = 1'b1;
            addr_d = idx_d;
        end
`ifdef SIGMAG_SCAN_CONT_EN
        done_d = (state_d == FIN);
`else
        if (state_d == FIN) begin
            done_d = 1'b1;
        end
`endif
    end

endmodule

// File: doc/sigmag_scan_ctrl.md
# sigmag_scan_ctrl

Sequencer for the sign/magnitude statistics engine. It steps the engine across a masked subset of ADC channels, one measurement window per channel, and writes each channel's sign and magnitude counts into a result store. Software issues one start instead of reprogramming the channel select and polling done per channel. It runs in the ADC clock domain between the bus register file and the statistics engine.

## Interface
- CH_NUM, 11, number of ADC channels (≤ 2^SEL_W)
- SEL_W, 5, channel-select width
- LEN_W, 25, window-length width (samples)
- CNTR_LENGTH, 24, engine counter width
- pclk  in  1  clock (ADC sample clock)
- presetn  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle scan request
- abort  in  1  one-cycle scan cancel
- ch_mask  in  CH_NUM  channels to measure; bit i = channel i
- length  in  LEN_W  samples per channel window
- meas_sel  out  SEL_W  engine channel select
- meas_len  out  LEN_W  engine window length
- meas_clr  out  1  one-cycle engine counter clear/start
- meas_done  in  1  engine done level
- meas_sig  in  CNTR_LENGTH  engine sign count
- meas_mag  in  CNTR_LENGTH  engine magnitude count
- res_we  out  1  result write strobe
- res_addr  out  SEL_W  result index = channel
- res_data  out  2*CNTR_LENGTH  {sig, mag}
- busy  out  1  scan in progress
- scan_done  out  1  sticky completion flag

## Operation
- FSM states: IDLE, SEEK, CLR, ARM, WAIT, STORE, FIN.
- IDLE: on start with length≠0, latch ch_mask and length, set idx=0, clear scan_done, go to SEEK. Ignore start when length=0.
- SEEK: if the latched mask bit [idx] is set, go to CLR. Otherwise, if idx=CH_NUM-1 go to FIN, else increment idx.
- CLR: drive meas_sel=idx, meas_len=latched length, meas_clr=1 for exactly one cycle, then go to ARM.
- ARM: wait for meas_done=0, so a stale done from the previous window is rejected. Then go to WAIT.
- WAIT: on meas_done=1, capture {meas_sig, meas_mag} and go to STORE.
- STORE: res_we=1 for one cycle with res_addr=idx. If idx=CH_NUM-1 go to FIN, else increment idx and go to SEEK.
- FIN: set scan_done=1 and go to IDLE.
- busy=1 in every state except IDLE.
- meas_sel and meas_len hold their last values outside CLR.
- start while busy is ignored.
- abort from any state: go to IDLE next cycle, no further res_we, scan_done stays 0.
- start and abort in the same cycle: abort wins.
- Empty mask: scan completes with no writes.
- Changes to ch_mask or length during a scan have no effect, because both are latched at start.

## Timing
- Reset values: every output is 0, the FSM is in IDLE, idx=0.
- start in cycle t gives busy=1 at t+1.
- Each skipped channel costs 1 cycle.
- An enabled channel costs CLR(1) + ARM(≥1) + engine latency + STORE(1).
- res_data is registered and valid in the same cycle as res_we.
- scan_done rises 1 cycle after the final STORE or SEEK. It clears on the next accepted start or on abort.
- Asserting presetn mid-scan returns everything to reset values asynchronously.

## Configuration
- SIGMAG_SCAN_CONT_EN defined: FIN pulses scan_done high for one cycle, resets idx=0 and re-enters SEEK. Scanning then repeats until abort, and busy stays 1.
- SIGMAG_SCAN_CONT_EN not defined: single-shot behaviour as described above.

## Structure
- Shared package sigmag_pkg holds:
  - the state enum scan_state_t
  - the CNTR_LENGTH, SEL_W and LEN_W defaults
  - a packed struct sigmag_res_t {sig, mag}, used for res_data.
- One sub-module, sigmag_ch_seek. It is a combinational next-enabled-channel search used by SEEK to skip runs of disabled channels.
- With sigmag_ch_seek, SEEK jumps straight to the next enabled channel in a single cycle instead of stepping one channel per cycle. This changes the per-skip cycle count above, so the bench must assume whichever variant is built.

## Test plan
- Mask 0b101, length 4, model engine done 4 cycles after meas_clr with sig=3, mag=1 → two writes, addr 0 then 2, data {3,1}; scan_done=1; busy=0.
- Mask 0 → no res_we; scan_done asserted within CH_NUM+2 cycles of start.
- meas_done held high from the prior window → no STORE until done goes low and then high again.
- abort during WAIT on channel 1 of mask 0b111 → only the addr 0 write occurs; IDLE next cycle; scan_done=0.
- start together with abort, or start with length=0 → busy stays 0.
- SIGMAG_SCAN_CONT_EN, mask 0b1 → repeated addr-0 writes and scan_done pulses until abort.
